// File: rtl/sdhc_reg_pkg.sv
// Shared constants for the SD host DMA register bank: byte offsets, register bit
// indices, the transfer FSM state type and the byte-lane merge helper.
package sdhc_reg_pkg;

  localparam logic [7:0] BLK_OFS  = 8'h04;
  localparam logic [7:0] TM_OFS   = 8'h0C;
  localparam logic [7:0] PS_OFS   = 8'h24;
  localparam logic [7:0] BGC_OFS  = 8'h28;
  localparam logic [7:0] SRST_OFS = 8'h2C;

  localparam int TM_BCE_BIT         = 1;
  localparam int TM_DIR_BIT         = 4;
  localparam int TM_MULTI_BIT       = 5;
  localparam int PS_CMD_INH_DAT_BIT = 1;
  localparam int PS_WR_ACT_BIT      = 8;
  localparam int PS_RD_ACT_BIT      = 9;
  localparam int BGC_STOP_BIT       = 0;
  localparam int BGC_CONT_BIT       = 1;
  localparam int CMD_DPS_BIT        = 21;  // Data Present Select, bus data bit
  localparam int SRST_DAT_BIT       = 26;  // Software Reset For DAT, bus data bit

  typedef enum logic [1:0] {
    XFER_IDLE     = 2'd0,
    XFER_ACTIVE   = 2'd1,
    XFER_GAP_STOP = 2'd2
  } xfer_state_e;

  function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  be);
    merge16 = {(be[1] ? new_val[15:8] : old_val[15:8]),
               (be[0] ? new_val[7:0]  : old_val[7:0])};
  endfunction

endpackage

// File: rtl/sdhc_xfer_fsm.sv
// Transfer sequencer: IDLE/ACTIVE/GAP_STOP, block counter, Present State
// transfer bits and the completion / block-gap pulses.
module sdhc_xfer_fsm
  import sdhc_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tm_bce,
  input  logic        tm_multi,
  input  logic        tm_dir,
  input  logic        bc_load,
  input  logic [15:0] bc_load_val,
  input  logic        block_done,
  input  logic        bgc_stop,
  input  logic        cont_req,
  input  logic        dat_reset,
  output xfer_state_e state,
  output logic [15:0] block_count,
  output logic [31:0] present_state,
  output logic        dma_run,
  output logic        xfer_complete,
  output logic        block_gap_event
);

  xfer_state_e state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [31:0] ps_r, ps_n;
  logic        dir_r, dir_n;
  logic        dma_run_r;
  logic        xc_r, xc_n;
  logic        bge_r, bge_n;
  logic        dec_s, last_s;

  assign dec_s  = tm_bce && tm_multi && (cnt_r != 16'd0);
  assign last_s = !tm_multi || (dec_s && (cnt_r == 16'd1));

  // Next-state, counter and Present State sequencing
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ps_n    = ps_r;
    dir_n   = dir_r;
    xc_n    = 1'b0;
    bge_n   = 1'b0;
    if (dat_reset) begin
      state_n = XFER_IDLE;
      cnt_n   = 16'd0;
      ps_n    = 32'd0;
    end else begin
      case (state_r)
        XFER_IDLE: begin
          if (start && tm_bce && tm_multi && (cnt_r == 16'd0)) begin
            xc_n = 1'b1;
          end else if (start) begin
            state_n                  = XFER_ACTIVE;
            dir_n                    = tm_dir;
            ps_n                     = 32'd0;
            ps_n[PS_RD_ACT_BIT]      = tm_dir;
            ps_n[PS_WR_ACT_BIT]      = !tm_dir;
            ps_n[PS_CMD_INH_DAT_BIT] = 1'b1;
          end else if (bc_load) begin
            cnt_n = bc_load_val;
          end else begin
            cnt_n = cnt_r;
          end
        end
        XFER_ACTIVE: begin
          if (block_done) begin
            if (dec_s) begin
              cnt_n = cnt_r - 16'd1;
            end else begin
              cnt_n = cnt_r;
            end
            if (last_s) begin
              state_n = XFER_IDLE;
              ps_n    = 32'd0;
              xc_n    = 1'b1;
            end else if (bgc_stop) begin
              // Command Inhibit DAT stays set while parked at the gap
              state_n             = XFER_GAP_STOP;
              ps_n[PS_RD_ACT_BIT] = 1'b0;
              ps_n[PS_WR_ACT_BIT] = 1'b0;
              bge_n               = 1'b1;
            end else begin
              state_n = XFER_ACTIVE;
            end
          end else begin
            state_n = XFER_ACTIVE;
          end
        end
        XFER_GAP_STOP: begin
          if (cont_req && !block_done) begin
            state_n             = XFER_ACTIVE;
            ps_n[PS_RD_ACT_BIT] = dir_r;
            ps_n[PS_WR_ACT_BIT] = !dir_r;
          end else begin
            state_n = XFER_GAP_STOP;
          end
        end
        default: begin
          state_n = XFER_IDLE;
          ps_n    = 32'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= XFER_IDLE;
      cnt_r     <= 16'd0;
      ps_r      <= 32'd0;
      dir_r     <= 1'b0;
      dma_run_r <= 1'b0;
      xc_r      <= 1'b0;
      bge_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      ps_r      <= ps_n;
      dir_r     <= dir_n;
      dma_run_r <= (state_n == XFER_ACTIVE);
      xc_r      <= xc_n;
      bge_r     <= bge_n;
    end
  end

  assign state           = state_r;
  assign block_count     = cnt_r;
  assign present_state   = ps_r;
  assign dma_run         = dma_run_r;
  assign xfer_complete   = xc_r;
  assign block_gap_event = bge_r;

endmodule

// File: rtl/sdhc_dma_reg_bank.sv
// SD host DMA register bank: bus decode, register storage and read mux.
// Optional Software Reset register enabled by defining SDHC_DAT_RESET_EN.
module sdhc_dma_reg_bank
  import sdhc_reg_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Wr_En,
  input  logic        Rd_En,
  input  logic [7:0]  Addr,
  input  logic [31:0] Wr_Data,
  input  logic [3:0]  Byte_En,
  output logic [31:0] Rd_Data,
  input  logic        Block_Done,
  output logic [15:0] Transfer_Mode_Register,
  output logic [15:0] Block_Count_Register,
  output logic [31:0] Present_State_Register,
  output logic [7:0]  Block_Gap_Control_Register,
  output logic        Dma_Run,
  output logic        Xfer_Complete,
  output logic        Block_Gap_Event
);

  logic [15:0] tm_r, bs_r;
  logic [7:0]  bgc_r;
  logic [31:0] rd_data_r, rd_mux_s, ps_s, srst_word_s;
  logic [15:0] tm_eff_s, bc_s;
  logic [7:0]  wa_s;
  logic        addr_unused_s;
  logic        wr_tm_s, wr_blk_s, wr_bgc_s, idle_s;
  logic        start_s, bc_load_s, cont_req_s, dat_reset_s;
  xfer_state_e state_s;

  assign addr_unused_s = ^Addr[1:0];
  assign wa_s          = {Addr[7:2], 2'b00};
  assign idle_s        = (state_s == XFER_IDLE);
  assign wr_tm_s       = Wr_En && (wa_s == TM_OFS);
  assign wr_blk_s      = Wr_En && (wa_s == BLK_OFS);
  assign wr_bgc_s      = Wr_En && (wa_s == BGC_OFS) && Byte_En[2];

  // A start that also writes Transfer Mode lanes uses the freshly written mode
  assign tm_eff_s   = (wr_tm_s && idle_s) ? merge16(tm_r, Wr_Data[15:0], Byte_En[1:0]) : tm_r;
  assign start_s    = wr_tm_s && Byte_En[3] && Wr_Data[CMD_DPS_BIT];
  assign bc_load_s  = wr_blk_s && (Byte_En[3] || Byte_En[2]);
  assign cont_req_s = wr_bgc_s && Wr_Data[16 + BGC_CONT_BIT] && !Wr_Data[16 + BGC_STOP_BIT];

`ifdef SDHC_DAT_RESET_EN
  logic srst_dat_r;
  logic wr_srst_s;

  assign wr_srst_s   = Wr_En && (wa_s == SRST_OFS) && Byte_En[3];
  assign dat_reset_s = wr_srst_s && Wr_Data[SRST_DAT_BIT];
  assign srst_word_s = {5'd0, srst_dat_r, 26'd0};

  // Software Reset For DAT is visible for one cycle, then self-clears
  always_ff @(posedge CLK) begin
    if (RESET) begin
      srst_dat_r <= 1'b0;
    end else begin
      srst_dat_r <= dat_reset_s;
    end
  end
`else
  assign dat_reset_s = 1'b0;
  assign srst_word_s = 32'd0;
`endif

  sdhc_xfer_fsm u_xfer_fsm (
    .clk             (CLK),
    .reset           (RESET),
    .start           (start_s),
    .tm_bce          (tm_eff_s[TM_BCE_BIT]),
    .tm_multi        (tm_eff_s[TM_MULTI_BIT]),
    .tm_dir          (tm_eff_s[TM_DIR_BIT]),
    .bc_load         (bc_load_s),
    .bc_load_val     (merge16(bc_s, Wr_Data[31:16], Byte_En[3:2])),
    .block_done      (Block_Done),
    .bgc_stop        (bgc_r[BGC_STOP_BIT]),
    .cont_req        (cont_req_s),
    .dat_reset       (dat_reset_s),
    .state           (state_s),
    .block_count     (bc_s),
    .present_state   (ps_s),
    .dma_run         (Dma_Run),
    .xfer_complete   (Xfer_Complete),
    .block_gap_event (Block_Gap_Event)
  );

  // Read mux over the pre-write register state
  always_comb begin
    rd_mux_s = 32'd0;
    case (wa_s)
      BLK_OFS:  rd_mux_s = {bc_s, bs_r};
      TM_OFS:   rd_mux_s = {16'd0, tm_r};
      PS_OFS:   rd_mux_s = ps_s;
      BGC_OFS:  rd_mux_s = {8'd0, bgc_r, 16'd0};
      SRST_OFS: rd_mux_s = srst_word_s;
      default:  rd_mux_s = 32'd0;
    endcase
  end

  // Register storage and registered read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tm_r      <= 16'd0;
      bs_r      <= 16'd0;
      bgc_r     <= 8'd0;
      rd_data_r <= 32'd0;
    end else begin
      tm_r <= tm_eff_s;
      if (wr_blk_s) begin
        bs_r <= merge16(bs_r, Wr_Data[15:0], Byte_En[1:0]);
      end
      if (dat_reset_s) begin
        bgc_r <= 8'd0;
      end else if (wr_bgc_s) begin
        bgc_r <= Wr_Data[23:16];
      end else begin
        bgc_r[BGC_CONT_BIT] <= 1'b0;
      end
      if (Rd_En) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  assign Rd_Data                    = rd_data_r;
  assign Transfer_Mode_Register     = tm_r;
  assign Block_Count_Register       = bc_s;
  assign Present_State_Register     = ps_s;
  assign Block_Gap_Control_Register = bgc_r;

endmodule

// File: tb/tb_sdhc_dma_reg_bank.sv
// Self-checking bench for sdhc_dma_reg_bank: read scoreboard plus per-scenario
// inline checks of the register outputs and pulses.
module tb_sdhc_dma_reg_bank;

  logic        CLK = 1'b0;
  logic        RESET, Wr_En, Rd_En, Block_Done;
  logic [7:0]  Addr;
  logic [31:0] Wr_Data;
  logic [3:0]  Byte_En;
  logic [31:0] Rd_Data, Present_State_Register;
  logic [15:0] Transfer_Mode_Register, Block_Count_Register;
  logic [7:0]  Block_Gap_Control_Register;
  logic        Dma_Run, Xfer_Complete, Block_Gap_Event;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  addr_q[$];

  sdhc_dma_reg_bank dut (
    .CLK                        (CLK),
    .RESET                      (RESET),
    .Wr_En                      (Wr_En),
    .Rd_En                      (Rd_En),
    .Addr                       (Addr),
    .Wr_Data                    (Wr_Data),
    .Byte_En                    (Byte_En),
    .Rd_Data                    (Rd_Data),
    .Block_Done                 (Block_Done),
    .Transfer_Mode_Register     (Transfer_Mode_Register),
    .Block_Count_Register       (Block_Count_Register),
    .Present_State_Register     (Present_State_Register),
    .Block_Gap_Control_Register (Block_Gap_Control_Register),
    .Dma_Run                    (Dma_Run),
    .Xfer_Complete              (Xfer_Complete),
    .Block_Gap_Event            (Block_Gap_Event)
  );

  always #5 CLK = ~CLK;

  // Read scoreboard: expected data was queued when Rd_En was driven
  always @(posedge CLK) begin
    if (Rd_En) begin
      logic [31:0] exp_v;
      logic [7:0]  a_v;
      #2;
      exp_v = exp_q.pop_front();
      a_v   = addr_q.pop_front();
      checks++;
      if (Rd_Data !== exp_v) begin
        errors++;
        $display("FAIL read@%02h got=%08h exp=%08h", a_v, Rd_Data, exp_v);
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    Wr_En = 1'b1; Addr = a; Wr_Data = d; Byte_En = be;
    @(negedge CLK);
    Wr_En = 1'b0; Byte_En = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp_v);
    Rd_En = 1'b1; Addr = a;
    exp_q.push_back(exp_v); addr_q.push_back(a);
    @(negedge CLK);
    Rd_En = 1'b0;
  endtask

  task automatic pulse_bd();
    Block_Done = 1'b1;
    @(negedge CLK);
    Block_Done = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Dma_Run !== 1'b0) begin errors++; $display("FAIL rst_dma_run got=%0b exp=0", Dma_Run); end
    checks++; if (Present_State_Register !== 32'h0) begin errors++; $display("FAIL rst_ps got=%08h exp=0", Present_State_Register); end
    checks++; if (Block_Count_Register !== 16'h0) begin errors++; $display("FAIL rst_bc got=%04h exp=0", Block_Count_Register); end
    checks++; if (Xfer_Complete !== 1'b0 || Block_Gap_Event !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%0b%0b exp=00", Xfer_Complete, Block_Gap_Event); end
    rd(8'h0C, 32'h0); rd(8'h04, 32'h0); rd(8'h24, 32'h0); rd(8'h28, 32'h0);
  endtask

  task automatic test_multi_block();
    logic [15:0] exp_bc[3] = '{16'd2, 16'd1, 16'd0};
    wr(8'h0C, 32'h0000_0023, 4'b0011);
    wr(8'h04, 32'h0003_0200, 4'b1111);
    rd(8'h04, 32'h0003_0200);
    wr(8'h0C, 32'h1220_0000, 4'b1000);
    checks++; if (Present_State_Register !== 32'h102) begin errors++; $display("FAIL mb_start_ps got=%08h exp=00000102", Present_State_Register); end
    checks++; if (Dma_Run !== 1'b1) begin errors++; $display("FAIL mb_start_run got=%0b exp=1", Dma_Run); end
    rd(8'h24, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      pulse_bd();
      checks++; if (Block_Count_Register !== exp_bc[i]) begin errors++; $display("FAIL mb_bc%0d got=%04h exp=%04h", i, Block_Count_Register, exp_bc[i]); end
      checks++; if (Xfer_Complete !== (i == 2)) begin errors++; $display("FAIL mb_xc%0d got=%0b exp=%0b", i, Xfer_Complete, (i == 2)); end
      if (i == 0) begin
        wr(8'h04, 32'h0007_0000, 4'b1100);
        wr(8'h0C, 32'h0000_0011, 4'b0011);
        checks++; if (Block_Count_Register !== 16'd2) begin errors++; $display("FAIL mb_bc_locked got=%04h exp=0002", Block_Count_Register); end
        checks++; if (Transfer_Mode_Register !== 16'h0023) begin errors++; $display("FAIL mb_tm_locked got=%04h exp=0023", Transfer_Mode_Register); end
      end
    end
    checks++; if (Present_State_Register !== 32'h0 || Dma_Run !== 1'b0) begin errors++; $display("FAIL mb_end got=%08h/%0b exp=0/0", Present_State_Register, Dma_Run); end
    @(negedge CLK);
    checks++; if (Xfer_Complete !== 1'b0) begin errors++; $display("FAIL mb_xc_width got=%0b exp=0", Xfer_Complete); end
  endtask

  task automatic test_block_gap();
    logic [15:0] exp_bc[3] = '{16'd2, 16'd1, 16'd0};
    wr(8'h0C, 32'h0000_0033, 4'b0011);
    wr(8'h04, 32'h0005_0000, 4'b1100);
    wr(8'h28, 32'h0001_0000, 4'b0100);
    wr(8'h0C, 32'h0020_0000, 4'b1100);
    checks++; if (Present_State_Register !== 32'h202) begin errors++; $display("FAIL gap_start_ps got=%08h exp=00000202", Present_State_Register); end
    pulse_bd();
    checks++; if (Present_State_Register !== 32'h002 || Block_Count_Register !== 16'd4) begin errors++; $display("FAIL gap_stop got=%08h/%04h exp=00000002/0004", Present_State_Register, Block_Count_Register); end
    checks++; if (Block_Gap_Event !== 1'b1 || Dma_Run !== 1'b0) begin errors++; $display("FAIL gap_event got=%0b/%0b exp=1/0", Block_Gap_Event, Dma_Run); end
    pulse_bd();
    checks++; if (Block_Gap_Event !== 1'b0 || Block_Count_Register !== 16'd4) begin errors++; $display("FAIL gap_bd_ignored got=%0b/%04h exp=0/0004", Block_Gap_Event, Block_Count_Register); end
    wr(8'h28, 32'h0003_0000, 4'b0100);
    checks++; if (Present_State_Register !== 32'h002) begin errors++; $display("FAIL gap_cont_stop_set got=%08h exp=00000002", Present_State_Register); end
    @(negedge CLK);
    checks++; if (Block_Gap_Control_Register !== 8'h01) begin errors++; $display("FAIL gap_cont_selfclr got=%02h exp=01", Block_Gap_Control_Register); end
    Block_Done = 1'b1;
    wr(8'h28, 32'h0002_0000, 4'b0100);
    Block_Done = 1'b0;
    checks++; if (Present_State_Register !== 32'h002 || Dma_Run !== 1'b0) begin errors++; $display("FAIL gap_cont_with_bd got=%08h/%0b exp=00000002/0", Present_State_Register, Dma_Run); end
    wr(8'h28, 32'h0002_0000, 4'b0100);
    checks++; if (Present_State_Register !== 32'h202 || Dma_Run !== 1'b1) begin errors++; $display("FAIL gap_continue got=%08h/%0b exp=00000202/1", Present_State_Register, Dma_Run); end
    @(negedge CLK);
    rd(8'h28, 32'h0);
    pulse_bd();
    checks++; if (Block_Count_Register !== 16'd3 || Dma_Run !== 1'b1) begin errors++; $display("FAIL gap_resume_bd got=%04h/%0b exp=0003/1", Block_Count_Register, Dma_Run); end
    for (int i = 0; i < 3; i++) begin
      pulse_bd();
      checks++; if (Block_Count_Register !== exp_bc[i] || Xfer_Complete !== (i == 2)) begin errors++; $display("FAIL gap_drain%0d got=%04h/%0b exp=%04h/%0b", i, Block_Count_Register, Xfer_Complete, exp_bc[i], (i == 2)); end
    end
  endtask

  task automatic test_zero_count();
    wr(8'h0C, 32'h0000_0022, 4'b0011);
    wr(8'h04, 32'h0000_0000, 4'b1100);
    wr(8'h0C, 32'h0020_0000, 4'b1100);
    checks++; if (Xfer_Complete !== 1'b1) begin errors++; $display("FAIL zc_xc got=%0b exp=1", Xfer_Complete); end
    checks++; if (Present_State_Register !== 32'h0 || Dma_Run !== 1'b0) begin errors++; $display("FAIL zc_idle got=%08h/%0b exp=0/0", Present_State_Register, Dma_Run); end
    @(negedge CLK);
    checks++; if (Xfer_Complete !== 1'b0) begin errors++; $display("FAIL zc_xc_width got=%0b exp=0", Xfer_Complete); end
  endtask

  task automatic test_idle_and_bus();
    wr(8'h04, 32'h0009_0000, 4'b1100);
    pulse_bd();
    checks++; if (Block_Count_Register !== 16'd9 || Xfer_Complete !== 1'b0 || Present_State_Register !== 32'h0) begin errors++; $display("FAIL idle_bd got=%04h/%0b/%08h exp=0009/0/0", Block_Count_Register, Xfer_Complete, Present_State_Register); end
    wr(8'h04, 32'h0001_0010, 4'b1111);
    Wr_En = 1'b1; Wr_Data = 32'h000A_0040; Byte_En = 4'hF;
    rd(8'h04, 32'h0001_0010);
    Wr_En = 1'b0; Byte_En = 4'h0;
    wr(8'h04, 32'hFFFF_FFFF, 4'b0001);
    rd(8'h04, 32'h000A_00FF);
    wr(8'h24, 32'hFFFF_FFFF, 4'hF);
    rd(8'h24, 32'h0);
    rd(8'h10, 32'h0);
  endtask

  task automatic test_abort();
    wr(8'h0C, 32'h0000_0023, 4'b0011);
    wr(8'h04, 32'h0003_0000, 4'b1100);
    wr(8'h0C, 32'h0020_0000, 4'b1100);
    pulse_bd();
    wr(8'h2C, 32'h0400_0000, 4'b1000);
`ifdef SDHC_DAT_RESET_EN
    checks++; if (Present_State_Register !== 32'h0 || Block_Count_Register !== 16'd0 || Dma_Run !== 1'b0 || Xfer_Complete !== 1'b0) begin errors++; $display("FAIL dat_reset got=%08h/%04h/%0b/%0b exp=0/0/0/0", Present_State_Register, Block_Count_Register, Dma_Run, Xfer_Complete); end
    @(negedge CLK);
    rd(8'h2C, 32'h0);
    wr(8'h04, 32'h0003_0000, 4'b1100);
    wr(8'h0C, 32'h0020_0000, 4'b1100);
    pulse_bd();
`else
    checks++; if (Present_State_Register !== 32'h102 || Block_Count_Register !== 16'd2 || Dma_Run !== 1'b1) begin errors++; $display("FAIL srst_ignored got=%08h/%04h/%0b exp=00000102/0002/1", Present_State_Register, Block_Count_Register, Dma_Run); end
    rd(8'h2C, 32'h0);
`endif
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if (Present_State_Register !== 32'h0 || Block_Count_Register !== 16'd0 || Dma_Run !== 1'b0 || Xfer_Complete !== 1'b0 || Transfer_Mode_Register !== 16'h0) begin errors++; $display("FAIL abort_reset got=%08h/%04h/%0b/%0b/%04h exp=all 0", Present_State_Register, Block_Count_Register, Dma_Run, Xfer_Complete, Transfer_Mode_Register); end
  endtask

  initial begin
    RESET = 1'b1; Wr_En = 1'b0; Rd_En = 1'b0; Block_Done = 1'b0;
    Addr = 8'h00; Wr_Data = 32'h0; Byte_En = 4'h0;
    @(negedge CLK);
    test_reset();
    test_multi_block();
    test_block_gap();
    test_zero_count();
    test_idle_and_bus();
    test_abort();
    @(negedge CLK);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdhc_dma_reg_bank.md
# sdhc_dma_reg_bank

Host-side register bank for the SD Host DMA path: it holds the Transfer Mode, Block Count, Block Gap Control and Present State registers and drives them to the DMA decode logic. It accepts CPU register writes and reads over a simple single-cycle bus. It sequences Present State transfer-active bits from command issue through block completions, block-gap stops and continues. It is the producer and owner of the register words that the DMA register decoder consumes.

## Interface
- No parameters; register offsets and bit indices are package constants.
- CLK  in  1  sole clock, all logic rising-edge.
- RESET  in  1  synchronous, active-high; clears every register and state.
- Wr_En  in  1  bus write strobe, one cycle per access.
- Rd_En  in  1  bus read strobe.
- Addr  in  8  byte address, word-aligned (bits [1:0] ignored).
- Wr_Data  in  32  write data.
- Byte_En  in  4  byte lane enables for writes.
- Rd_Data  out  32  read data, registered.
- Block_Done  in  1  one-cycle pulse from DMA engine: one block fully moved.
- Transfer_Mode_Register  out  16  offset 0x0C low half.
- Block_Count_Register  out  16  offset 0x04 high half.
- Present_State_Register  out  32  offset 0x24, read-only.
- Block_Gap_Control_Register  out  8  offset 0x28 byte 2.
- Dma_Run  out  1  high while the transfer FSM is ACTIVE.
- Xfer_Complete  out  1  one-cycle pulse at transfer end.
- Block_Gap_Event  out  1  one-cycle pulse on entering GAP_STOP.

## Operation
- Reset values: all register outputs 0, Rd_Data 0, Dma_Run/Xfer_Complete/Block_Gap_Event 0, FSM IDLE.
- Writes use byte lanes; Transfer Mode and Block Count writes are dropped unless FSM is IDLE. Block Size (0x04 low half) is stored and read back.
- Present State bits: [9] Read Transfer Active, [8] Write Transfer Active, [1] Command Inhibit DAT. Other bits read 0. Bus writes to 0x24 are ignored.
- Start: write with Byte_En[3] at 0x0C and Wr_Data[21]=1 (Data Present Select). This start is accepted only in IDLE. Direction is Transfer Mode [4]: 1 sets PS[9], 0 sets PS[8]. PS[1] is set in both cases. FSM goes to ACTIVE.
- Start while Transfer Mode [1]=1, [5]=1 and Block Count=0: no transfer. Xfer_Complete pulses and the FSM stays IDLE.
- FSM states: IDLE, ACTIVE, GAP_STOP.
- ACTIVE + Block_Done:
  - Block count decrements if Transfer Mode [1] (Block Count Enable) and [5] (Multi) are both set.
  - Transfer ends if single-block ([5]=0), or count decremented from 1 to 0. On end: PS[9:8,1] clear, Xfer_Complete pulses, state goes to IDLE.
  - Otherwise, if BGC[0] (Stop At Block Gap) is set: go to GAP_STOP, clear PS[9:8] but keep PS[1], pulse Block_Gap_Event.
  - Otherwise: remain ACTIVE.
- BGC[1] Continue Request:
  - Write-1 pulse; the stored bit self-clears the next cycle.
  - In GAP_STOP with BGC[0]=0 after the write, the FSM returns to ACTIVE and restores the PS direction bit.
  - Otherwise the write is ignored.
- Block_Done in IDLE or GAP_STOP is ignored. A Continue write in the same cycle as Block_Done is ignored.
- RESET mid-transfer aborts immediately to reset values, with no Xfer_Complete.

## Timing
- Write takes effect on the register outputs the cycle after Wr_En.
- Start at cycle N: PS bits and Dma_Run are valid at N+1.
- Block_Done at N: count, PS, state and pulses are all updated at N+1.
- Read: Rd_Data is valid the cycle after Rd_En and reflects state sampled at the Rd_En edge. Unmapped addresses return 0.
- Wr_En and Rd_En in the same cycle: the read returns the pre-write value.

## Configuration
- SDHC_DAT_RESET_EN defined: adds the Software Reset register at 0x2C byte 3. Writing bit 2 (Software Reset For DAT) does the following on the next cycle:
  - forces the FSM to IDLE;
  - clears PS[9:8,1], BGC and Block Count;
  - asserts no Xfer_Complete;
  - self-clears the bit.
- Not defined: the 0x2C write is ignored and reads return 0.

## Structure
- Package sdhc_reg_pkg: register offsets, Present State / Transfer Mode / BGC bit indices, FSM state enum.
- One sub-module, sdhc_xfer_fsm: IDLE/ACTIVE/GAP_STOP sequencing, block counter and pulses. The top level holds the bus decode and register storage.

## Test plan
- Reset, then read 0x0C/0x04/0x24/0x28 -> all 0. Dma_Run=0.
- Write TM=0x0023 (multi, count enable, DMA, write), BC=3, then start. Apply 3 Block_Done pulses -> BC 2,1,0. Xfer_Complete fires on the 3rd pulse. PS 0x102 returns to 0x000.
- TM=0x0033 (read), BC=5, BGC[0]=1. After 1 Block_Done -> GAP_STOP, PS=0x002, BC=4, Block_Gap_Event. Write BGC=0x02 -> ACTIVE, PS=0x202, BGC reads 0x00.
- Start with TM=0x0022, BC=0 -> Xfer_Complete next cycle, PS stays 0.
- Write BC=7 while ACTIVE -> BC unchanged. Block_Done while IDLE -> no change.
- With SDHC_DAT_RESET_EN: mid-transfer write 0x04000000 to 0x2C -> IDLE, PS=0, BC=0, no Xfer_Complete.
